// File: rtl/mem_port_master.sv
// Initiator for the single-port maze memory: valid/ready requests in, one-cycle read response out.
// Defining MEM_CLEAR_EN adds a sequencer that zeroes every memory word on clear_start.
module mem_port_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_command,
`ifdef MEM_CLEAR_EN
    input  logic              clear_start,
    output logic              clear_done,
`endif
    inout  wire  [DATA_W-1:0] mem_data
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
`ifdef MEM_CLEAR_EN
        ,
        CLEAR = 2'd3
`endif
    } state_t;

    state_t            state_p0;
    state_t            next_state;
    logic              accept;
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;

    logic              cmd_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic              rd_vld_p1;

`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_p0;
    logic              clr_last_p1;
    logic              clr_done_p2;
`endif

    // Stage p0: request acceptance and sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= next_state;
        end
    end

    always_comb begin
        next_state = state_p0;
        req_ready  = 1'b0;
        case (state_p0)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    next_state = req_write ? WRITE : READ;
                end
`ifdef MEM_CLEAR_EN
                // A clear wins over a simultaneous request, which stays pending
                if (clear_start) begin
                    req_ready  = 1'b0;
                    next_state = CLEAR;
                end
`endif
            end
            WRITE:   next_state = IDLE;
            READ:    next_state = IDLE;
`ifdef MEM_CLEAR_EN
            CLEAR: begin
                if (clr_cnt_p0 == {ADDR_W{1'b1}}) begin
                    next_state = IDLE;
                end
            end
`endif
            default: next_state = IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;
    assign busy   = (state_p0 != IDLE);

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

`ifdef MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt_p0 <= '0;
        end else if (state_p0 == CLEAR) begin
            clr_cnt_p0 <= clr_cnt_p0 + ADDR_W'(1);
        end else begin
            clr_cnt_p0 <= '0;
        end
    end
`endif

    // Stage p1: memory bus cycle; command idles high so the memory never sees a stray write
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_p1    <= 1'b1;
            addr_p1   <= '0;
            rd_vld_p1 <= 1'b0;
        end else begin
            cmd_p1    <= 1'b1;
            rd_vld_p1 <= 1'b0;
            case (state_p0)
                WRITE: begin
                    cmd_p1  <= 1'b0;
                    addr_p1 <= addr_p0;
                end
                READ: begin
                    addr_p1   <= addr_p0;
                    rd_vld_p1 <= 1'b1;
                end
`ifdef MEM_CLEAR_EN
                CLEAR: begin
                    cmd_p1  <= 1'b0;
                    addr_p1 <= clr_cnt_p0;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state_p0)
            WRITE:   wdata_p1 <= wdata_p0;
`ifdef MEM_CLEAR_EN
            CLEAR:   wdata_p1 <= '0;
`endif
            default: wdata_p1 <= wdata_p1;
        endcase
    end

`ifdef MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_last_p1 <= 1'b0;
        end else begin
            clr_last_p1 <= (state_p0 == CLEAR) && (clr_cnt_p0 == {ADDR_W{1'b1}});
        end
    end
`endif

    assign mem_address = addr_p1;
    assign mem_command = cmd_p1;
    // Output enable comes from the command register itself, so turnaround needs no gap cycle
    assign mem_data    = cmd_p1 ? {DATA_W{1'bz}} : wdata_p1;

    // Stage p2: read capture and response strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= rd_vld_p1;
            if (rd_vld_p1) begin
                rsp_rdata <= mem_data;
            end
        end
    end

`ifdef MEM_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_done_p2 <= 1'b0;
        end else begin
            clr_done_p2 <= clr_last_p1;
        end
    end

    assign clear_done = clr_done_p2;
`endif

endmodule
